// File: rtl/ram_initiator_pkg.sv
// Op and state encodings for the RAM initiator, shared with the core's memory stage.
package ram_initiator_pkg;

  typedef enum logic [1:0] {
    OP_READ  = 2'd0,
    OP_WRITE = 2'd1,
    OP_FILL  = 2'd2,
    OP_NOP   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_SAMPLE = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  function automatic logic is_store(input op_e op);
    return (op == OP_WRITE) || (op == OP_FILL);
  endfunction

endpackage

// File: rtl/ram_initiator_if.sv
// Command/response handshake between the core's memory stage (master) and the initiator (slave).
interface ram_initiator_if
  import ram_initiator_pkg::*;
#(
  parameter int addr_bits = 16,
  parameter int data_bits = 8
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  op_e                  cmd_op;
  logic [addr_bits-1:0] cmd_addr;
  logic [data_bits-1:0] cmd_data;
  logic [addr_bits-1:0] cmd_len;
  logic                 rsp_valid;
  logic [data_bits-1:0] rsp_data;

  modport master (
    output cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_len,
    input  cmd_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_addr, cmd_data, cmd_len,
    output cmd_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/ram_fill_counter.sv
// Loadable down-counter for FILL word counts; last is registered and means count==1.
module ram_fill_counter #(
  parameter int width = 17
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [width-1:0] load_value,
  input  logic             dec,
  output logic             last
);
  localparam logic [width-1:0] one = {{(width-1){1'b0}}, 1'b1};
  localparam logic [width-1:0] two = {{(width-2){1'b0}}, 2'b10};

  logic [width-1:0] count_r;
  logic             last_r;

  // Count register; last is precomputed so it comes straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= {width{1'b0}};
      last_r  <= 1'b0;
    end else if (load) begin
      count_r <= load_value;
      last_r  <= (load_value == one);
    end else if (dec) begin
      count_r <= count_r - one;
      last_r  <= (count_r == two);
    end else begin
      count_r <= count_r;
      last_r  <= last_r;
    end
  end

  assign last = last_r;
endmodule

// File: rtl/ram_initiator.sv
// Initiator for an unclocked RAM port: sequences setup/strobe/hold around every write
// and returns read data or completion over a one-cycle response pulse.
module ram_initiator
  import ram_initiator_pkg::*;
#(
  parameter int addr_bits = 16,
  parameter int data_bits = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ram_initiator_if.slave       bus,
  output logic                 ram_we,
  output logic [addr_bits-1:0] ram_addr,
  output logic [data_bits-1:0] ram_wdata,
  input  logic [data_bits-1:0] ram_rdata
);
  localparam logic [addr_bits-1:0] addr_one = {{(addr_bits-1){1'b0}}, 1'b1};

  state_e               state_r, state_s;
  op_e                  op_r, op_s;
  logic                 ram_we_r, ram_we_s;
  logic [addr_bits-1:0] ram_addr_r, ram_addr_s;
  logic [data_bits-1:0] ram_wdata_r, ram_wdata_s;
  logic                 rsp_valid_r, rsp_valid_s;
  logic [data_bits-1:0] rsp_data_r, rsp_data_s;
  logic                 cmd_ready_r, cmd_ready_s;
  logic                 cnt_load_s, cnt_dec_s, cnt_last_s;
  logic [addr_bits:0]   cnt_value_s;

  ram_fill_counter #(.width(addr_bits + 1)) u_fill_counter (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (cnt_load_s),
    .load_value (cnt_value_s),
    .dec        (cnt_dec_s),
    .last       (cnt_last_s)
  );

  // A zero length means the whole address space.
  always_comb begin
    if (bus.cmd_len == {addr_bits{1'b0}}) begin
      cnt_value_s = {1'b1, {addr_bits{1'b0}}};
    end else begin
      cnt_value_s = {1'b0, bus.cmd_len};
    end
  end

  // Next-state and next-output logic; ram_we and ram_addr never change on the same edge.
  always_comb begin
    state_s     = state_r;
    op_s        = op_r;
    ram_we_s    = 1'b0;
    ram_addr_s  = ram_addr_r;
    ram_wdata_s = ram_wdata_r;
    rsp_valid_s = 1'b0;
    rsp_data_s  = rsp_data_r;
    cmd_ready_s = 1'b0;
    cnt_load_s  = 1'b0;
    cnt_dec_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        cmd_ready_s = 1'b1;
        if (bus.cmd_valid && cmd_ready_r) begin
          cmd_ready_s = 1'b0;
          op_s        = bus.cmd_op;
          if (bus.cmd_op == OP_NOP) begin
            state_s     = ST_RESP;
            rsp_valid_s = 1'b1;
          end else begin
            state_s     = ST_SETUP;
            ram_addr_s  = bus.cmd_addr;
            ram_wdata_s = bus.cmd_data;
            cnt_load_s  = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (is_store(op_r)) begin
          state_s  = ST_STROBE;
          ram_we_s = 1'b1;
        end else begin
          state_s = ST_SAMPLE;
        end
      end
      ST_STROBE: begin
        state_s = ST_HOLD;
      end
      ST_HOLD: begin
        if ((op_r != OP_FILL) || cnt_last_s) begin
          state_s     = ST_RESP;
          rsp_valid_s = 1'b1;
        end else begin
          state_s    = ST_SETUP;
          cnt_dec_s  = 1'b1;
          ram_addr_s = ram_addr_r + addr_one;
        end
      end
      ST_SAMPLE: begin
        state_s     = ST_RESP;
        rsp_data_s  = ram_rdata;
        rsp_valid_s = 1'b1;
      end
      ST_RESP: begin
        state_s     = ST_IDLE;
        cmd_ready_s = 1'b1;
      end
      default: begin
        state_s     = ST_IDLE;
        cmd_ready_s = 1'b1;
      end
    endcase
  end

  // State and output registers; reset drops any write pulse immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      op_r        <= OP_NOP;
      ram_we_r    <= 1'b0;
      ram_addr_r  <= {addr_bits{1'b0}};
      ram_wdata_r <= {data_bits{1'b0}};
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {data_bits{1'b0}};
      cmd_ready_r <= 1'b1;
    end else begin
      state_r     <= state_s;
      op_r        <= op_s;
      ram_we_r    <= ram_we_s;
      ram_addr_r  <= ram_addr_s;
      ram_wdata_r <= ram_wdata_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_data_r  <= rsp_data_s;
      cmd_ready_r <= cmd_ready_s;
    end
  end

  assign ram_we        = ram_we_r;
  assign ram_addr      = ram_addr_r;
  assign ram_wdata     = ram_wdata_r;
  assign bus.cmd_ready = cmd_ready_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_data  = rsp_data_r;
endmodule
